// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: in-order pipeline writeback vs. queued MDU results.
// Optional starvation guard compiled in with `define WB_ARB_STARVE_GUARD_EN.
module wb_port_arbiter #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pipe_valid,
   input  logic [4:0]  pipe_wa,
   input  logic [63:0] pipe_wd,
   input  logic        mdu_valid,
   input  logic [4:0]  mdu_wa,
   input  logic [63:0] mdu_wd,
   output logic        mdu_ready,
   output logic        pipe_stall,
   output logic        pending,
   output logic [4:0]  wa,
   output logic [63:0] wd,
   output logic        wvalid
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [4:0]    fifo_wa [DEPTH];
   logic [63:0]   fifo_wd [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;

   logic pipe_req;
   logic fifo_nonempty;
   logic guard_fire;
   logic pipe_grant;
   logic fifo_grant;
   logic push;
   logic pop;

   assign pipe_req      = pipe_valid && (pipe_wa != 5'd0);
   assign fifo_nonempty = (count != '0);
   assign mdu_ready     = (count != CW'(DEPTH));
   assign pending       = fifo_nonempty;

   // x0 results complete the handshake but are dropped
   assign push = mdu_valid && mdu_ready && (mdu_wa != 5'd0);

   assign pipe_grant = pipe_req && !guard_fire;
   assign fifo_grant = fifo_nonempty && (guard_fire || !pipe_req);
   assign pop        = fifo_grant;
   assign pipe_stall = guard_fire;

`ifdef WB_ARB_STARVE_GUARD_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   logic [SW-1:0] starve_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (!fifo_nonempty || fifo_grant) begin
         starve_cnt <= '0;
      end else if (pipe_grant && (starve_cnt != SW'(STARVE_LIMIT))) begin
         starve_cnt <= starve_cnt + SW'(1);
      end
   end

   assign guard_fire = fifo_nonempty && (starve_cnt == SW'(STARVE_LIMIT));
`else
   assign guard_fire = 1'b0;
`endif

   always_comb begin
      wvalid = 1'b0;
      wa     = 5'd0;
      wd     = 64'd0;
      if (pipe_grant) begin
         wvalid = 1'b1;
         wa     = pipe_wa;
         wd     = pipe_wd;
      end else if (fifo_grant) begin
         wvalid = 1'b1;
         wa     = fifo_wa[rd_ptr];
         wd     = fifo_wd[rd_ptr];
      end
   end

   // Queue storage is data only; validity is tracked by count
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_wa[wr_ptr] <= mdu_wa;
         fifo_wd[wr_ptr] <= mdu_wd;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
